// File: rtl/sample_decimator.sv
// sample_decimator: averages windows of 2^r signed samples and emits one
// decimated sample per window with a one-cycle strobe. Feeds the waveform
// display capture path (new_sample / sample inputs).
// Optional build macro: SAMPLE_DECIMATOR_PEAK_EN adds a per-window peak
// magnitude tracker driving peak_out; without it peak_out is tied to 0.
module sample_decimator #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_LOG2 = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_in,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    play,
  input  logic                    flush,
  input  logic [2:0]              ratio_log2,
  output logic                    new_sample_out,
  output logic [WIDTH-1:0]        sample_out,
  output logic [WIDTH-1:0]        peak_out
);

  localparam int unsigned AW = WIDTH + MAX_LOG2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [MAX_LOG2:0]      count_q, count_d;
  logic [2:0]             ratio_q, ratio_d;
  logic [WIDTH-1:0]       sample_out_q, sample_out_d;
  logic                   strobe_q, strobe_d;

  logic                   accept;
  logic [2:0]             ratio_clamped;
  logic signed [AW-1:0]   sample_ext;
  logic signed [AW-1:0]   sum;
  logic [MAX_LOG2:0]      last_cnt;

`ifdef SAMPLE_DECIMATOR_PEAK_EN
  logic [WIDTH-1:0]       peak_q, peak_d;
  logic [WIDTH-1:0]       peak_out_q, peak_out_d;
  logic [WIDTH-1:0]       abs_in;
  logic [WIDTH-1:0]       peak_max;
`endif

  assign accept        = new_sample_in & play & ~flush;
  assign ratio_clamped = (ratio_log2 > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : ratio_log2;
  assign sample_ext    = AW'(sample_in);
  assign sum           = acc_q + sample_ext;
  assign last_cnt      = ({{MAX_LOG2{1'b0}}, 1'b1} << ratio_q) - 1'b1;

`ifdef SAMPLE_DECIMATOR_PEAK_EN
  // Saturating magnitude of the incoming sample and running window maximum
  always_comb begin
    if (sample_in == {1'b1, {(WIDTH-1){1'b0}}}) begin
      abs_in = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (sample_in[WIDTH-1]) begin
      abs_in = -sample_in;
    end else begin
      abs_in = sample_in;
    end
    peak_max = (abs_in > peak_q) ? abs_in : peak_q;
  end
`endif

  // Next-state and datapath control for the IDLE/ACCUM window FSM
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    ratio_d      = ratio_q;
    sample_out_d = sample_out_q;
    strobe_d     = 1'b0;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
    peak_d       = peak_q;
    peak_out_d   = peak_out_q;
`endif

    if (state_q == IDLE) begin
      ratio_d = ratio_clamped;
    end

    if (flush) begin
      acc_d   = '0;
      count_d = '0;
      state_d = IDLE;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
      peak_d  = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (ratio_q == '0) begin
              sample_out_d = sample_in;
              strobe_d     = 1'b1;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
              peak_out_d   = abs_in;
`endif
            end else begin
              acc_d   = sample_ext;
              count_d = {{MAX_LOG2{1'b0}}, 1'b1};
              state_d = ACCUM;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
              peak_d  = abs_in;
`endif
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            if (count_q == last_cnt) begin
              sample_out_d = WIDTH'(sum >>> ratio_q);
              strobe_d     = 1'b1;
              acc_d        = '0;
              count_d      = '0;
              state_d      = IDLE;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
              peak_out_d   = peak_max;
              peak_d       = '0;
`endif
            end else begin
              acc_d   = sum;
              count_d = count_q + 1'b1;
`ifdef SAMPLE_DECIMATOR_PEAK_EN
              peak_d  = peak_max;
`endif
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      count_q      <= '0;
      ratio_q      <= '0;
      sample_out_q <= '0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      ratio_q      <= ratio_d;
      sample_out_q <= sample_out_d;
      strobe_q     <= strobe_d;
    end
  end

`ifdef SAMPLE_DECIMATOR_PEAK_EN
  // Peak tracker registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_q     <= '0;
      peak_out_q <= '0;
    end else begin
      peak_q     <= peak_d;
      peak_out_q <= peak_out_d;
    end
  end

  assign peak_out = peak_out_q;
`else
  assign peak_out = '0;
`endif

  assign new_sample_out = strobe_q;
  assign sample_out     = sample_out_q;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed self-checking bench for sample_decimator. Inputs are driven 1 ns
// after the rising edge; outputs are checked at the same point, i.e. after
// the registered outputs have settled from the preceding edge.
module tb_sample_decimator;

`ifdef SAMPLE_DECIMATOR_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        new_sample_in;
  logic [15:0] sample_in;
  logic        play;
  logic        flush;
  logic [2:0]  ratio_log2;
  logic        new_sample_out;
  logic [15:0] sample_out;
  logic [15:0] peak_out;

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int mark;

  sample_decimator #(.WIDTH(16), .MAX_LOG2(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .new_sample_in  (new_sample_in),
    .sample_in      (sample_in),
    .play           (play),
    .flush          (flush),
    .ratio_log2     (ratio_log2),
    .new_sample_out (new_sample_out),
    .sample_out     (sample_out),
    .peak_out       (peak_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (new_sample_out === 1'b1) strobes++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] v);
    new_sample_in = 1'b1;
    sample_in     = v;
    tick();
    new_sample_in = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic [15:0] v);
    return PEAK ? {16'h0, v} : 32'h0;
  endfunction

  initial begin
    reset = 1'b0; new_sample_in = 1'b0; sample_in = '0;
    play = 1'b1; flush = 1'b0; ratio_log2 = 3'd0;
    idle(2);
    check("rst_strobe", {31'h0, new_sample_out}, 32'h0);
    check("rst_sample", {16'h0, sample_out}, 32'h0);
    check("rst_peak",   {16'h0, peak_out}, 32'h0);
    reset = 1'b1;

    // Reset mid-window
    ratio_log2 = 3'd1; idle(2);
    mark = strobes;
    send(16'd100);
    reset = 1'b0; idle(2);
    check("midrst_strobe", {31'h0, new_sample_out}, 32'h0);
    check("midrst_sample", {16'h0, sample_out}, 32'h0);
    check("midrst_peak",   {16'h0, peak_out}, 32'h0);
    reset = 1'b1; idle(2);
    check("midrst_no_emit", strobes - mark, 32'd0);
    send(16'd4);
    check("midrst_first", {31'h0, new_sample_out}, 32'h0);
    send(16'd8);
    check("midrst_strobe_out", {31'h0, new_sample_out}, 32'h1);
    check("midrst_avg", {16'h0, sample_out}, 32'd6);
    check("midrst_peak8", {16'h0, peak_out}, pk(16'd8));

    // Pass-through on consecutive cycles
    ratio_log2 = 3'd0; idle(2);
    mark = strobes;
    send(16'h8000);
    check("pt0_strobe", {31'h0, new_sample_out}, 32'h1);
    check("pt0_sample", {16'h0, sample_out}, 32'h8000);
    check("pt0_peak",   {16'h0, peak_out}, pk(16'h7FFF));
    send(16'h7FFF);
    check("pt1_strobe", {31'h0, new_sample_out}, 32'h1);
    check("pt1_sample", {16'h0, sample_out}, 32'h7FFF);
    check("pt1_peak",   {16'h0, peak_out}, pk(16'h7FFF));
    tick();
    check("pt_after", {31'h0, new_sample_out}, 32'h0);
    check("pt_hold",  {16'h0, sample_out}, 32'h7FFF);

    // Floor rounding of a negative average
    ratio_log2 = 3'd2; idle(2);
    mark = strobes;
    send(16'hFFFC); send(16'hFFFC); send(16'hFFFC);
    send(16'hFFFD);
    check("neg_avg", {16'h0, sample_out}, 32'h0000FFFC);
    check("neg_peak", {16'h0, peak_out}, pk(16'd4));
    tick();
    check("neg_one_strobe", strobes - mark, 32'd1);

    // Ratio change mid-window applies to the next window
    ratio_log2 = 3'd1; idle(2);
    mark = strobes;
    send(16'd10);
    ratio_log2 = 3'd2;
    send(16'd20);
    check("chg_first", {16'h0, sample_out}, 32'd15);
    idle(2);
    send(16'd1); send(16'd2); send(16'd3);
    check("chg_mid_nostrobe", {31'h0, new_sample_out}, 32'h0);
    send(16'd6);
    check("chg_second", {16'h0, sample_out}, 32'd3);
    tick();
    check("chg_strobes", strobes - mark, 32'd2);

    // ratio_log2 = 7 clamps to a 16-sample window
    ratio_log2 = 3'd7; idle(2);
    mark = strobes;
    for (int i = 1; i <= 15; i++) send(16'(i));
    check("clamp_15_none", strobes - mark, 32'd0);
    send(16'd16);
    check("clamp_strobe", {31'h0, new_sample_out}, 32'h1);
    check("clamp_avg", {16'h0, sample_out}, 32'd8);
    check("clamp_peak", {16'h0, peak_out}, pk(16'd16));

    // play freeze then flush
    ratio_log2 = 3'd1; idle(2);
    mark = strobes;
    send(16'd6);
    play = 1'b0;
    send(16'd1000); send(16'd1000); send(16'd1000);
    play = 1'b1;
    check("freeze_none", strobes - mark, 32'd0);
    send(16'd8);
    check("freeze_avg", {16'h0, sample_out}, 32'd7);
    check("freeze_peak", {16'h0, peak_out}, pk(16'd8));
    tick();
    check("freeze_strobes", strobes - mark, 32'd1);
    mark = strobes;
    send(16'd50);
    flush = 1'b1;
    send(16'd99);
    flush = 1'b0;
    check("flush_nostrobe", {31'h0, new_sample_out}, 32'h0);
    check("flush_hold", {16'h0, sample_out}, 32'd7);
    send(16'd2);
    send(16'd4);
    check("flush_avg", {16'h0, sample_out}, 32'd3);
    check("flush_peak", {16'h0, peak_out}, pk(16'd4));
    tick();
    check("flush_strobes", strobes - mark, 32'd1);

    // Max window with extreme values
    ratio_log2 = 3'd4; idle(2);
    mark = strobes;
    for (int i = 0; i < 16; i++) send(16'h7FFF);
    check("max_avg", {16'h0, sample_out}, 32'h7FFF);
    check("max_peak", {16'h0, peak_out}, pk(16'h7FFF));
    send(16'h8000);
    send(16'd5);
    for (int i = 0; i < 14; i++) send(16'h0000);
    check("min_avg", {16'h0, sample_out}, 32'h0000F800);
    check("min_peak", {16'h0, peak_out}, pk(16'h7FFF));
    tick();
    check("max_strobes", strobes - mark, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
